charge_discharge_seq: RTL and testbench
=======================================

# charge_discharge_seq

Parametrised start/charge/discharge sequencer for the delay signal generator front end. A start request is synchronised, and the block then drives a fixed-length first-charge pulse to all channels. It enables the delay counters and holds each channel's discharge line until that channel's counter reports completion or a programmable timeout expires. It is fully synchronous (no latches, single clock edge), supports N channels, an optional retrigger mode, and reports overrun and timeout status.

## Interface
Parameters:
- N_CH, 4, number of delay channels
- FC_LEN, 2, first-charge pulse length in clock cycles (≥1)
- TO_W, 16, width of the timeout counter and of i_timeout
- RETRIG, 0, 1 = a start edge during an active sequence restarts it; 0 = the edge is ignored

Ports:
- i_clk  in  1  system clock; one clock domain, all logic on posedge
- i_reset_n  in  1  asynchronous active-low reset
- i_start  in  1  asynchronous start request; high ≥2 i_clk cycles
- i_arm  in  1  synchronous enable; start edges are ignored while low
- i_reset_ch  in  N_CH  per-channel completion pulse from the delay counters, synchronous
- i_timeout  in  TO_W  RUN-state timeout in cycles; 0 = timeout disabled
- o_first_charge  out  1  first-charge pulse
- o_discharge  out  N_CH  per-channel discharge hold
- o_startcounter  out  1  delay-counter enable
- o_busy  out  1  high whenever state ≠ IDLE
- o_overrun  out  1  one-cycle pulse: a start edge arrived while not IDLE
- o_timeout_ch  out  N_CH  sticky flags: channel released by timeout

## Operation
- i_start passes a 2-FF synchroniser, then a rising-edge detector (sync2 & ~sync2_d).
- States are IDLE, CHARGE, RUN.
- IDLE:
  - Outputs: o_discharge=0, o_first_charge=0, o_startcounter=0.
  - An accepted edge is one with i_arm=1.
  - On an accepted edge: go to CHARGE, load the charge counter with FC_LEN-1, and clear o_timeout_ch.
- CHARGE:
  - Outputs: o_first_charge=1, o_discharge=all ones.
  - i_reset_ch is ignored.
  - When the charge counter reaches 0: go to RUN and clear the run counter.
- RUN:
  - Outputs: o_startcounter=1.
  - The run counter increments each cycle and saturates at all ones.
  - i_reset_ch[i]=1 clears o_discharge[i].
  - If i_timeout≠0 and the run counter equals i_timeout-1: clear every still-set o_discharge bit and set the matching o_timeout_ch bit.
  - If the next value of o_discharge is all zero: go to IDLE on the same edge.
- Start edge while not IDLE:
  - o_overrun pulses for one cycle.
  - RETRIG=1 with i_arm=1: re-enter CHARGE exactly as from IDLE.
  - RETRIG=0: the state is unaffected.
- Simultaneous events:
  - i_reset_ch[i] and timeout on the same cycle: i_reset_ch wins, and o_timeout_ch[i] is not set.
  - i_reset_ch for a channel already cleared: no effect.
- i_reset_n low, at any time including mid-sequence: the state goes to IDLE immediately. All outputs, synchroniser stages and counters go to 0.

## Timing
- Reset values: o_first_charge=0, o_discharge=0, o_startcounter=0, o_busy=0, o_overrun=0, o_timeout_ch=0.
- Every output is driven directly from registers; there are no combinational paths from input to output.
- i_start is first sampled high at edge k; o_first_charge and o_discharge go high after edge k+2.
- o_first_charge stays high for exactly FC_LEN cycles. It falls at edge k+2+FC_LEN, and o_startcounter rises on the same edge.
- i_reset_ch[i] is sampled high at edge m in RUN; o_discharge[i] falls after edge m.
- Timeout: o_discharge falls after exactly i_timeout cycles in RUN, counting the RUN entry edge as cycle 1.
- o_startcounter and o_busy fall on the same edge as the last o_discharge bit.
- o_overrun goes high for the one cycle after the FSM edge that saw the start edge.

## Structure
- Shared package charge_seq_pkg holds:
  - typedef enum logic [1:0] {IDLE, CHARGE, RUN} for the state
  - the default parameter constants
- Sub-module sync_2ff, the parametrised-width 2-FF synchroniser with async active-low reset, instantiated for i_start.

## Test plan
- Reset, N_CH=4, FC_LEN=2: hold i_reset_n=0 with i_start=1 → every output stays 0; release → still 0 until a fresh rising edge of i_start.
- Start at edge k with i_arm=1 and i_timeout=0 → o_first_charge high over k+2..k+3; o_startcounter rises at k+4; i_reset_ch pulses 1,2,4,8 at k+10/12/14/16 → discharge bits fall on those edges; o_busy falls at k+16.
- i_timeout=5, only ch0 reset at RUN cycle 2 → ch1–3 fall after RUN cycle 5; o_timeout_ch=4'b1110; the next accepted start clears it.
- i_reset_ch[2] on the exact timeout cycle → o_timeout_ch[2]=0 and the other flags are set.
- Second start edge in RUN: RETRIG=0 → o_overrun pulse, sequence continues; RETRIG=1 → o_overrun pulse, re-entry to CHARGE, all discharge bits set again, run counter restarted.
- i_arm=0 during a start edge → no state change and no o_overrun from IDLE; async i_reset_n low mid-RUN → all outputs 0 with no i_clk edge needed.

Source files
------------

// File: rtl/charge_seq_pkg.sv
// Shared types and default parameter values for the charge/discharge sequencer.
package charge_seq_pkg;

  typedef enum logic [1:0] {IDLE, CHARGE, RUN} state_e;

  localparam int unsigned DEF_N_CH   = 4;
  localparam int unsigned DEF_FC_LEN = 2;
  localparam int unsigned DEF_TO_W   = 16;
  localparam bit          DEF_RETRIG = 1'b0;

endpackage

// File: rtl/sync_2ff.sv
// Parametrised-width two-flop synchroniser with asynchronous active-low reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/charge_discharge_seq.sv
// Start/charge/discharge sequencer: synchronised start, fixed first-charge pulse,
// per-channel discharge hold released by counter completion or run timeout.
module charge_discharge_seq
  import charge_seq_pkg::*;
#(
  parameter int unsigned N_CH   = DEF_N_CH,
  parameter int unsigned FC_LEN = DEF_FC_LEN,
  parameter int unsigned TO_W   = DEF_TO_W,
  parameter bit          RETRIG = DEF_RETRIG
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_start,
  input  logic            i_arm,
  input  logic [N_CH-1:0] i_reset_ch,
  input  logic [TO_W-1:0] i_timeout,
  output logic            o_first_charge,
  output logic [N_CH-1:0] o_discharge,
  output logic            o_startcounter,
  output logic            o_busy,
  output logic            o_overrun,
  output logic [N_CH-1:0] o_timeout_ch
);

  localparam int unsigned CHG_W = (FC_LEN > 1) ? $clog2(FC_LEN) : 1;
  localparam logic [CHG_W-1:0] CHG_LOAD = CHG_W'(FC_LEN - 1);

  state_e            r_state;
  logic              r_sync_d;
  logic [CHG_W-1:0]  r_chg_cnt;
  logic [TO_W-1:0]   r_run_cnt;
  logic              r_first_charge;
  logic [N_CH-1:0]   r_discharge;
  logic              r_startcounter;
  logic              r_busy;
  logic              r_overrun;
  logic [N_CH-1:0]   r_timeout_ch;

  logic              w_sync;
  logic              w_start_edge;
  logic              w_accept;
  logic              w_to_hit;
  logic [N_CH-1:0]   w_dis_after_rst;
  logic [N_CH-1:0]   w_dis_next;
  logic [N_CH-1:0]   w_to_set;

  sync_2ff #(
    .WIDTH (1)
  ) u_start_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_d       (i_start),
    .o_q       (w_sync)
  );

  always_comb begin
    w_start_edge    = w_sync & ~r_sync_d;
    w_accept        = w_start_edge && i_arm && ((r_state == IDLE) || RETRIG);
    w_to_hit        = (i_timeout != '0) && (r_run_cnt == (i_timeout - TO_W'(1)));
    // Completion pulses are applied before the timeout so they win on a tie.
    w_dis_after_rst = r_discharge & ~i_reset_ch;
    w_dis_next      = w_to_hit ? '0 : w_dis_after_rst;
    w_to_set        = w_to_hit ? w_dis_after_rst : '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state        <= IDLE;
      r_sync_d       <= 1'b0;
      r_chg_cnt      <= '0;
      r_run_cnt      <= '0;
      r_first_charge <= 1'b0;
      r_discharge    <= '0;
      r_startcounter <= 1'b0;
      r_busy         <= 1'b0;
      r_overrun      <= 1'b0;
      r_timeout_ch   <= '0;
    end else begin
      r_sync_d  <= w_sync;
      r_overrun <= w_start_edge && (r_state != IDLE);
      if (w_accept) begin
        r_state        <= CHARGE;
        r_chg_cnt      <= CHG_LOAD;
        r_timeout_ch   <= '0;
        r_first_charge <= 1'b1;
        r_discharge    <= '1;
        r_startcounter <= 1'b0;
        r_busy         <= 1'b1;
      end else begin
        unique case (r_state)
          IDLE: begin
          end
          CHARGE: begin
            if (r_chg_cnt == '0) begin
              r_state        <= RUN;
              r_run_cnt      <= '0;
              r_first_charge <= 1'b0;
              r_startcounter <= 1'b1;
            end else begin
              r_chg_cnt <= r_chg_cnt - CHG_W'(1);
            end
          end
          RUN: begin
            if (r_run_cnt != '1) begin
              r_run_cnt <= r_run_cnt + TO_W'(1);
            end
            r_discharge  <= w_dis_next;
            r_timeout_ch <= r_timeout_ch | w_to_set;
            if (w_dis_next == '0) begin
              r_state        <= IDLE;
              r_startcounter <= 1'b0;
              r_busy         <= 1'b0;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign o_first_charge = r_first_charge;
  assign o_discharge    = r_discharge;
  assign o_startcounter = r_startcounter;
  assign o_busy         = r_busy;
  assign o_overrun      = r_overrun;
  assign o_timeout_ch   = r_timeout_ch;

endmodule

// File: tb/tb_charge_discharge_seq.sv
// Bench for charge_discharge_seq: RETRIG=0 and RETRIG=1 instances share stimulus and
// are compared every cycle against a phase-level reference model.
module tb_charge_discharge_seq;

  localparam int FC_LEN    = 2;
  localparam int PH_IDLE   = 0;
  localparam int PH_CHARGE = 1;
  localparam int PH_RUN    = 2;

  typedef struct {
    int         phase;
    int         chg_left;
    int         elapsed;
    logic [3:0] dis;
    logic [3:0] tof;
    logic       ovr;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        arm;
  logic [3:0]  rch;
  logic [15:0] tmo;

  logic       fc0, sc0, busy0, ovr0;
  logic [3:0] dis0, tof0;
  logic       fc1, sc1, busy1, ovr1;
  logic [3:0] dis1, tof1;
  logic [11:0] out0, out1;

  int   n_vec = 0;
  int   n_err = 0;
  int   hold_q = 0;
  mdl_t m0, m1;
  logic samp_q[$];

  always #5 clk = ~clk;

  assign out0 = {fc0, dis0, sc0, busy0, ovr0, tof0};
  assign out1 = {fc1, dis1, sc1, busy1, ovr1, tof1};

  charge_discharge_seq #(
    .N_CH(4), .FC_LEN(FC_LEN), .TO_W(16), .RETRIG(1'b0)
  ) dut0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_arm(arm), .i_reset_ch(rch),
    .i_timeout(tmo), .o_first_charge(fc0), .o_discharge(dis0), .o_startcounter(sc0),
    .o_busy(busy0), .o_overrun(ovr0), .o_timeout_ch(tof0)
  );

  charge_discharge_seq #(
    .N_CH(4), .FC_LEN(FC_LEN), .TO_W(16), .RETRIG(1'b1)
  ) dut1 (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_arm(arm), .i_reset_ch(rch),
    .i_timeout(tmo), .o_first_charge(fc1), .o_discharge(dis1), .o_startcounter(sc1),
    .o_busy(busy1), .o_overrun(ovr1), .o_timeout_ch(tof1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.phase = PH_IDLE; m.chg_left = 0; m.elapsed = 0;
    m.dis = '0; m.tof = '0; m.ovr = 1'b0;
    return m;
  endfunction

  // One clock edge of the sequencer, described in terms of phases and elapsed cycles.
  function automatic mdl_t mdl_step(mdl_t m, logic edge_s, logic arm_s, logic [3:0] rch_s,
                                    logic [15:0] tmo_s, bit retrig);
    mdl_t n;
    n = m;
    n.ovr = edge_s && (m.phase != PH_IDLE);
    if (edge_s && arm_s && (m.phase == PH_IDLE || retrig)) begin
      n.phase = PH_CHARGE; n.chg_left = FC_LEN; n.tof = '0; n.dis = '1;
    end else if (m.phase == PH_CHARGE) begin
      if (m.chg_left == 1) begin
        n.phase = PH_RUN; n.elapsed = 1;
      end else begin
        n.chg_left = m.chg_left - 1;
      end
    end else if (m.phase == PH_RUN) begin
      n.dis = m.dis & ~rch_s;
      if (tmo_s != 0 && m.elapsed == int'(tmo_s)) begin
        n.tof = m.tof | n.dis;
        n.dis = '0;
      end
      n.elapsed = m.elapsed + 1;
      if (n.dis == '0) n.phase = PH_IDLE;
    end
    return n;
  endfunction

  function automatic logic [11:0] mdl_out(mdl_t m);
    return {m.phase == PH_CHARGE, m.dis, m.phase == PH_RUN, m.phase != PH_IDLE, m.ovr, m.tof};
  endfunction

  // Advance one clock, update the model with the inputs seen at the edge, then compare.
  task automatic step();
    logic e;
    @(posedge clk);
    if (!rst_n) begin
      m0 = mdl_reset();
      m1 = mdl_reset();
      samp_q = '{1'b0, 1'b0, 1'b0};
    end else begin
      // A start sample becomes a recognised edge two clocks after it is taken.
      e = samp_q[1] && !samp_q[0];
      m0 = mdl_step(m0, e, arm, rch, tmo, 1'b0);
      m1 = mdl_step(m1, e, arm, rch, tmo, 1'b1);
      samp_q.push_back(start);
      void'(samp_q.pop_front());
    end
    #1;
    check("model_r0", out0, mdl_out(m0));
    check("model_r1", out1, mdl_out(m1));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; arm = 1'b1; rch = '0; tmo = '0;
    m0 = mdl_reset(); m1 = mdl_reset();
    samp_q = '{1'b0, 1'b0, 1'b0};

    // Reset held with start high, then released with arm low.
    for (int c = 0; c < 4; c++) begin
      step();
      check("rst_outs0", out0, 12'h0);
    end
    rst_n = 1'b1; arm = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("rel_busy", busy0, 1'b0);
    arm = 1'b1;
    for (int c = 0; c < 3; c++) step();
    check("no_edge_busy", busy0, 1'b0);
    start = 1'b0;
    for (int c = 0; c < 3; c++) step();

    // Basic sequence, channels released one by one.
    tmo = '0;
    for (int c = 0; c <= 17; c++) begin
      start = (c < 2);
      rch = (c == 10) ? 4'h1 : (c == 12) ? 4'h2 : (c == 14) ? 4'h4 : (c == 16) ? 4'h8 : 4'h0;
      step();
      if (c == 1) check("fc_pre", fc0, 1'b0);
      if (c == 2 || c == 3) check("fc_high", fc0, 1'b1);
      if (c == 4) begin
        check("fc_fall", fc0, 1'b0);
        check("sc_rise", sc0, 1'b1);
      end
      if (c == 10) check("dis_ch0", dis0, 4'hE);
      if (c == 15) check("busy_hold", busy0, 1'b1);
      if (c == 16) begin
        check("busy_fall", busy0, 1'b0);
        check("sc_fall", sc0, 1'b0);
      end
    end

    // Timeout of 5 with only ch0 completed.
    tmo = 16'd5;
    for (int c = 0; c <= 12; c++) begin
      start = (c < 2);
      rch = (c == 5) ? 4'h1 : 4'h0;
      step();
      if (c == 8) check("to_pre", dis0, 4'hE);
      if (c == 9) begin
        check("to_dis", dis0, 4'h0);
        check("to_flags", tof0, 4'hE);
      end
    end

    // Completion on the timeout cycle wins; next start clears old flags.
    for (int c = 0; c <= 12; c++) begin
      start = (c < 2);
      rch = (c == 9) ? 4'h4 : 4'h0;
      step();
      if (c == 1) check("flags_kept", tof0, 4'hE);
      if (c == 2) check("flags_clr", tof0, 4'h0);
      if (c == 9) check("to_tie", tof0, 4'hB);
    end

    // Second start edge during RUN.
    tmo = '0;
    for (int c = 0; c <= 20; c++) begin
      start = (c < 2) || (c == 6) || (c == 7);
      rch = (c == 14) ? 4'hF : 4'h0;
      step();
      if (c == 8) begin
        check("ovr_r0", ovr0, 1'b1);
        check("cont_r0", {fc0, sc0}, 2'b01);
        check("ovr_r1", ovr1, 1'b1);
        check("retrig_r1", {fc1, dis1}, 5'h1F);
      end
      if (c == 9) check("ovr_pulse", ovr0, 1'b0);
      if (c == 14) check("both_idle", {busy0, busy1}, 2'b00);
    end

    // Start edge with arm low from IDLE.
    arm = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      start = (c < 2);
      step();
      if (c == 2) check("unarmed", {busy0, ovr0}, 2'b00);
    end
    arm = 1'b1;

    // Asynchronous reset mid-RUN.
    for (int c = 0; c <= 6; c++) begin
      start = (c < 2);
      step();
    end
    #3 rst_n = 1'b0;
    #1;
    check("async_rst0", out0, 12'h0);
    check("async_rst1", out1, 12'h0);
    step();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) step();

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      if (hold_q > 0) begin
        start = 1'b1;
        hold_q--;
      end else if ($urandom_range(0, 11) == 0) begin
        start = 1'b1;
        hold_q = $urandom_range(1, 3);
      end else begin
        start = 1'b0;
      end
      arm = ($urandom_range(0, 9) != 0);
      rch = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 39) == 0) tmo = 16'($urandom_range(0, 12));
      rst_n = ($urandom_range(0, 599) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
